// File: rtl/cordic_rot_iter.sv
// Iterative CORDIC rotation engine: binary angle in, cosine/sine out, one micro-rotation per clock.
// Optional: define CORDIC_GAIN_COMP_EN to pre-scale x0 by 1/K so results come out at unit amplitude.
module cordic_rot_iter #(
  parameter int WIDTH = 16,
  parameter int ITER  = 14
) (
  input  logic             clk,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] angle_in,
  output logic             ready_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] cos_out,
  output logic [WIDTH-1:0] sin_out
);

  localparam int XW = WIDTH + 2;
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] QTR = WIDTH'(1 << (WIDTH - 2));

`ifdef CORDIC_GAIN_COMP_EN
  localparam longint X0_L = (64'd6072529 * (64'd1 << (WIDTH - 2)) + 64'd5000000) / 64'd10000000;
`else
  localparam longint X0_L = 64'd1 << (WIDTH - 2);
`endif
  localparam logic signed [XW-1:0] X0 = XW'(X0_L);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
  logic signed [WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0]       cos_q, cos_d, sin_q, sin_d;
  logic                   valid_q, valid_d, ready_q, ready_d;

  // Table is in 2^16-per-turn units; rescale to WIDTH bits rounding half up.
  function automatic logic [WIDTH-1:0] atan_lut(input logic [CW-1:0] i);
    int v;
    v = 0;
    case (int'(i))
      0:  v = 8192;
      1:  v = 4836;
      2:  v = 2555;
      3:  v = 1297;
      4:  v = 651;
      5:  v = 326;
      6:  v = 163;
      7:  v = 81;
      8:  v = 41;
      9:  v = 20;
      10: v = 10;
      11: v = 5;
      12: v = 3;
      13: v = 1;
      14: v = 1;
      default: v = 0;
    endcase
    v = (((v << 1) >>> (16 - WIDTH)) + 1) >>> 1;
    return WIDTH'(v);
  endfunction

  function automatic logic [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] hi, lo;
    hi = {3'b000, {(WIDTH-1){1'b1}}};
    lo = {3'b111, {(WIDTH-1){1'b0}}};
    if (v > hi)      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (v < lo) return {1'b1, {(WIDTH-1){1'b0}}};
    else             return v[WIDTH-1:0];
  endfunction

  logic                    d_pos;
  logic signed [XW-1:0]    x_sh, y_sh, x_n, y_n;
  logic signed [WIDTH-1:0] atan_i, z_n;

  always_comb begin
    d_pos  = ~z_q[WIDTH-1];
    x_sh   = x_q >>> cnt_q;
    y_sh   = y_q >>> cnt_q;
    atan_i = $signed(atan_lut(cnt_q));
    x_n    = d_pos ? x_q - y_sh : x_q + y_sh;
    y_n    = d_pos ? y_q + x_sh : y_q - x_sh;
    z_n    = d_pos ? z_q - atan_i : z_q + atan_i;
  end

  always_comb begin
    // NOTE: every _d gets a default up front so no path through the case infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          cnt_d   = '0;
          state_d = RUN;
          // Fold quadrants 01/10 by a +-90 degree pre-rotation so z stays within +-90.
          case (angle_in[WIDTH-1 -: 2])
            2'b01: begin
              x_d = '0;
              y_d = X0;
              z_d = $signed(angle_in - QTR);
            end
            2'b10: begin
              x_d = '0;
              y_d = -X0;
              z_d = $signed(angle_in + QTR);
            end
            default: begin
              x_d = X0;
              y_d = '0;
              z_d = $signed(angle_in);
            end
          endcase
        end
      end
      RUN: begin
        x_d   = x_n;
        y_d   = y_n;
        z_d   = z_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          cos_d   = sat(x_n);
          sin_d   = sat(y_n);
          valid_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values of its neighbours.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign ready_out = ready_q;
  assign valid_out = valid_q;
  assign cos_out   = cos_q;
  assign sin_out   = sin_q;

endmodule

// File: tb/tb_cordic_rot_iter.sv
// Directed bench for cordic_rot_iter at WIDTH=16, ITER=14; expected amplitudes follow CORDIC_GAIN_COMP_EN.
module tb_cordic_rot_iter;

  localparam int WIDTH = 16;
  localparam int ITER  = 14;
  localparam int TOL   = 8;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int AMP = 16384;
  localparam int A45 = 11585;
`else
  localparam int AMP = 26981;
  localparam int A45 = 19079;
`endif

  logic             clk = 1'b0;
  logic             rst_n_in;
  logic             start_in;
  logic [WIDTH-1:0] angle_in;
  logic             ready_out;
  logic             valid_out;
  logic [WIDTH-1:0] cos_out;
  logic [WIDTH-1:0] sin_out;

  int n_checks = 0;
  int n_fail   = 0;

  cordic_rot_iter #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clk       (clk),
    .rst_n_in  (rst_n_in),
    .start_in  (start_in),
    .angle_in  (angle_in),
    .ready_out (ready_out),
    .valid_out (valid_out),
    .cos_out   (cos_out),
    .sin_out   (sin_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [WIDTH-1:0] raw, input int exp);
    int got, diff;
    got  = int'($signed(raw));
    diff = (got > exp) ? got - exp : exp - got;
    n_checks++;
    assert (diff <= TOL) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d +-%0d", tag, got, exp, TOL);
    end
  endtask

  // Leaves the caller on a falling edge with ready_out high, or flags a timeout.
  task automatic wait_ready(input string tag);
    int k;
    for (k = 0; k < 50 && !ready_out; k++) @(negedge clk);
    check_eq({tag, "_ready_wait"}, int'(ready_out), 1);
  endtask

  // Counts falling edges after the accept edge until valid_out; -1 if it never comes.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 3 * ITER; k++) begin
      @(negedge clk);
      if (valid_out) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_angle(input string tag, input logic [WIDTH-1:0] ang, input int ec, input int es);
    int lat;
    wait_ready(tag);
    start_in = 1'b1;
    angle_in = ang;
    @(negedge clk);
    start_in = 1'b0;
    angle_in = 16'h5a5a;
    wait_valid(lat);
    check_eq({tag, "_latency"}, lat, ITER);
    check_near({tag, "_cos"}, cos_out, ec);
    check_near({tag, "_sin"}, sin_out, es);
    @(negedge clk);
    check_eq({tag, "_valid_drop"}, int'(valid_out), 0);
    check_eq({tag, "_ready_back"}, int'(ready_out), 1);
  endtask

  initial begin
    int lat, extra;
    rst_n_in = 1'b0;
    start_in = 1'b0;
    angle_in = '0;
    repeat (2) @(negedge clk);
    rst_n_in = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", int'(ready_out), 1);
    check_eq("rst_valid", int'(valid_out), 0);
    check_eq("rst_cos", int'(cos_out), 0);
    check_eq("rst_sin", int'(sin_out), 0);

    run_angle("a0",    16'sd0,     AMP, 0);
    run_angle("a90",   16'sd16384, 0,   AMP);
    run_angle("a45",   16'sd8192,  A45, A45);
    run_angle("am180", 16'h8000,   -AMP, 0);
    run_angle("am45",  -16'sd8192, A45, -A45);

    // start held high through RUN and DONE with a changing angle: one result, first angle.
    wait_ready("busy");
    start_in = 1'b1;
    angle_in = 16'sd8192;
    @(negedge clk);
    angle_in = -16'sd8192;
    wait_valid(lat);
    check_eq("busy_latency", lat, ITER);
    check_near("busy_cos", cos_out, A45);
    check_near("busy_sin", sin_out, A45);
    @(negedge clk);
    start_in = 1'b0;
    check_eq("busy_ready_back", int'(ready_out), 1);
    extra = 0;
    repeat (ITER + 4) begin
      @(negedge clk);
      if (valid_out) extra++;
    end
    check_eq("busy_no_second_valid", extra, 0);

    // Reset in the middle of a run clears everything at once and suppresses the result.
    wait_ready("mid_rst");
    start_in = 1'b1;
    angle_in = 16'sd16384;
    @(negedge clk);
    start_in = 1'b0;
    repeat (5) @(negedge clk);
    rst_n_in = 1'b0;
    #1;
    check_eq("mid_rst_cos", int'(cos_out), 0);
    check_eq("mid_rst_sin", int'(sin_out), 0);
    check_eq("mid_rst_valid", int'(valid_out), 0);
    check_eq("mid_rst_ready", int'(ready_out), 1);
    repeat (2) @(negedge clk);
    rst_n_in = 1'b1;
    extra = 0;
    repeat (ITER + 4) begin
      @(negedge clk);
      if (valid_out) extra++;
    end
    check_eq("mid_rst_no_valid", extra, 0);
    run_angle("post_rst", 16'sd0, AMP, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
